// File: rtl/gumnut_pc_sequencer.sv
// Program-counter sequencer for the Gumnut core: runs the BOOT/FETCH/DECODE/EXECUTE/RET_WAIT
// sequence, drives the return-address stack and tracks its occupancy.
module gumnut_pc_sequencer #(
    parameter int              PC_W      = 12,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              STK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            stall_i,
    input  logic            jmp_i,
    input  logic            jsb_i,
    input  logic            ret_i,
    input  logic            br_i,
    input  logic            cond_i,
    input  logic [PC_W-1:0] target_i,
    input  logic [7:0]      disp_i,
    input  logic [PC_W-1:0] stk_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_o,
    output logic            push_o,
    output logic            pop_o,
    output logic [PC_W-1:0] ret_addr_o,
    output logic [3:0]      depth_o,
    output logic            stk_err_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_RET_WAIT
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [3:0]      DEPTH_MAX = 4'(STK_DEPTH);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [3:0]      depth_nxt;
    logic            err_nxt;
    logic            resolve;
    logic            do_push;
    logic            do_pop;
    logic [PC_W-1:0] disp_ext;

    // Decoded ops are resolved by priority ret > jsb > jmp > br only when EXECUTE is not stalled.
    assign resolve    = (state == S_EXECUTE) && !stall_i;
    assign do_pop     = resolve && ret_i;
    assign do_push    = resolve && !ret_i && jsb_i;
    assign disp_ext   = {{(PC_W-8){disp_i[7]}}, disp_i};
    assign ret_addr_o = pc_o + PC_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            pc_o      <= RESET_VEC;
            depth_o   <= '0;
            stk_err_o <= 1'b0;
        end else if (cen) begin
            state     <= state_nxt;
            pc_o      <= pc_nxt;
            depth_o   <= depth_nxt;
            stk_err_o <= err_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_o;
        depth_nxt = depth_o;
        err_nxt   = stk_err_o;
        unique case (state)
            S_BOOT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (!stall_i) begin
                    state_nxt = S_FETCH;
                    if (ret_i) begin
                        state_nxt = S_RET_WAIT;
                    end else if (jsb_i || jmp_i) begin
                        pc_nxt = target_i;
                    end else if (br_i && cond_i) begin
                        pc_nxt = pc_o + PC_ONE + disp_ext;
                    end else begin
                        pc_nxt = pc_o + PC_ONE;
                    end
                end
            end
            S_RET_WAIT: begin
                pc_nxt    = stk_pc_i;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_BOOT;
        endcase

        // The stack is still pushed/popped on overflow/underflow; only the count saturates.
        if (do_push) begin
            if (depth_o == DEPTH_MAX) err_nxt = 1'b1;
            else                      depth_nxt = depth_o + 4'd1;
        end else if (do_pop) begin
            if (depth_o == 4'd0) err_nxt = 1'b1;
            else                 depth_nxt = depth_o - 4'd1;
        end
    end

    // Stack strobes are qualified by cen so the gated stack clock sees each op exactly once.
    always_comb begin
        fetch_o = (state == S_FETCH);
        push_o  = cen && do_push;
        pop_o   = cen && do_pop;
    end

endmodule

// File: tb/tb_gumnut_pc_sequencer.sv
// Directed bench for gumnut_pc_sequencer: sequencing, call/return, branches, depth tracking,
// stall/clock-enable holds and asynchronous reset abort.
module tb_gumnut_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        stall_i, jmp_i, jsb_i, ret_i, br_i, cond_i;
    logic [11:0] target_i;
    logic [7:0]  disp_i;
    logic [11:0] stk_pc_i;
    logic [11:0] pc_o;
    logic        fetch_o, push_o, pop_o;
    logic [11:0] ret_addr_o;
    logic [3:0]  depth_o;
    logic        stk_err_o;

    int checks = 0;
    int errors = 0;

    gumnut_pc_sequencer #(
        .PC_W(12), .RESET_VEC(12'h000), .STK_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .stall_i(stall_i),
        .jmp_i(jmp_i), .jsb_i(jsb_i), .ret_i(ret_i), .br_i(br_i), .cond_i(cond_i),
        .target_i(target_i), .disp_i(disp_i), .stk_pc_i(stk_pc_i),
        .pc_o(pc_o), .fetch_o(fetch_o), .push_o(push_o), .pop_o(pop_o),
        .ret_addr_o(ret_addr_o), .depth_o(depth_o), .stk_err_o(stk_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ops();
        stall_i = 1'b0; jmp_i = 1'b0; jsb_i = 1'b0; ret_i = 1'b0; br_i = 1'b0; cond_i = 1'b0;
    endtask

    // From FETCH, advance through DECODE into EXECUTE.
    task automatic goto_exec();
        step();
        step();
    endtask

    // Reset, release, and land in the first FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", 32'(pc_o), 32'h000);
        check("rst_depth", 32'(depth_o), 0);
        check("rst_err", 32'(stk_err_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic exec_jmp(input logic [11:0] tgt);
        goto_exec();
        jmp_i = 1'b1; target_i = tgt;
        step();
        clr_ops();
    endtask

    task automatic exec_br(input logic [7:0] disp, input logic cond, input logic [11:0] exp_pc,
                           input string tag);
        goto_exec();
        br_i = 1'b1; cond_i = cond; disp_i = disp;
        step();
        clr_ops();
        check(tag, 32'(pc_o), 32'(exp_pc));
    endtask

    initial begin
        int n_push;
        rst_n = 1'b0; cen = 1'b1; clr_ops();
        target_i = '0; disp_i = '0; stk_pc_i = '0;
        #12;
        check("rst_fetch", 32'(fetch_o), 0);
        check("rst_push", 32'(push_o), 0);
        check("rst_pop", 32'(pop_o), 0);

        // 1: sequential cadence from reset.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("seq_fetch%0d", k), 32'(fetch_o), (k % 3 == 0) ? 1 : 0);
            check($sformatf("seq_pc%0d", k), 32'(pc_o), 32'(k / 3));
            if (k < 6) step();
        end

        // 2: call and return (ret also has jsb asserted; ret must win).
        exec_jmp(12'h010);
        check("jmp_pc", 32'(pc_o), 32'h010);
        goto_exec();
        jsb_i = 1'b1; target_i = 12'h200;
        #1;
        check("jsb_push", 32'(push_o), 1);
        check("jsb_pop", 32'(pop_o), 0);
        check("jsb_ret_addr", 32'(ret_addr_o), 32'h011);
        step();
        clr_ops();
        check("jsb_push_end", 32'(push_o), 0);
        check("jsb_pc", 32'(pc_o), 32'h200);
        check("jsb_depth", 32'(depth_o), 1);
        goto_exec();
        ret_i = 1'b1; jsb_i = 1'b1; target_i = 12'h333;
        #1;
        check("ret_pop", 32'(pop_o), 1);
        check("ret_no_push", 32'(push_o), 0);
        step();
        clr_ops();
        stk_pc_i = 12'h011;
        check("retw_pop", 32'(pop_o), 0);
        check("retw_fetch", 32'(fetch_o), 0);
        check("retw_depth", 32'(depth_o), 0);
        check("retw_pc_hold", 32'(pc_o), 32'h200);
        step();
        check("ret_pc", 32'(pc_o), 32'h011);
        check("ret_fetch", 32'(fetch_o), 1);
        check("ret_err", 32'(stk_err_o), 0);

        // 3: branches and wrap-around.
        exec_jmp(12'h005);
        exec_br(8'hFA, 1'b1, 12'h000, "br_back_to0");
        exec_br(8'h20, 1'b0, 12'h001, "br_not_taken");
        exec_br(8'hFC, 1'b1, 12'hFFE, "br_wrap_neg");
        exec_jmp(12'hFFF);
        goto_exec();
        step();
        check("seq_wrap", 32'(pc_o), 32'h000);

        // 4: overflow after 9 nested calls, then underflow on a fresh stack.
        for (int i = 0; i < 9; i++) begin
            goto_exec();
            jsb_i = 1'b1; target_i = 12'h100 + 12'(i);
            #1;
            check($sformatf("nest_push%0d", i), 32'(push_o), 1);
            step();
            clr_ops();
            if (i == 7) begin
                check("nest8_depth", 32'(depth_o), 8);
                check("nest8_err", 32'(stk_err_o), 0);
            end
        end
        check("ovf_depth", 32'(depth_o), 8);
        check("ovf_err", 32'(stk_err_o), 1);
        check("ovf_pc", 32'(pc_o), 32'h108);
        do_reset();
        goto_exec();
        ret_i = 1'b1;
        #1;
        check("udf_pop", 32'(pop_o), 1);
        step();
        clr_ops();
        check("udf_err", 32'(stk_err_o), 1);
        check("udf_depth", 32'(depth_o), 0);
        stk_pc_i = 12'h040;
        step();
        check("udf_ret_pc", 32'(pc_o), 32'h040);

        // 5: stall then clock-enable low in EXECUTE with jsb pending.
        goto_exec();
        jsb_i = 1'b1; target_i = 12'h300; stall_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("stall_push%0d", j), 32'(push_o), 0);
            check($sformatf("stall_pc%0d", j), 32'(pc_o), 32'h040);
            step();
        end
        stall_i = 1'b0; cen = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("cen_push%0d", j), 32'(push_o), 0);
            check($sformatf("cen_pc%0d", j), 32'(pc_o), 32'h040);
            check($sformatf("cen_fetch%0d", j), 32'(fetch_o), 0);
            step();
        end
        cen = 1'b1;
        n_push = 0;
        for (int j = 0; j < 2; j++) begin
            #1;
            if (push_o) n_push++;
            if (j == 0) step();
        end
        clr_ops();
        check("release_pushes", 32'(n_push), 1);
        check("release_pc", 32'(pc_o), 32'h300);
        check("release_depth", 32'(depth_o), 1);

        // 6: reset asserted while waiting on a return.
        goto_exec();
        jsb_i = 1'b1; target_i = 12'h320;
        step();
        clr_ops();
        goto_exec();
        ret_i = 1'b1;
        step();
        stk_pc_i = 12'h555;
        check("abort_pre_depth", 32'(depth_o), 1);
        check("abort_pre_err", 32'(stk_err_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pc", 32'(pc_o), 32'h000);
        check("abort_depth", 32'(depth_o), 0);
        check("abort_err", 32'(stk_err_o), 0);
        check("abort_fetch", 32'(fetch_o), 0);
        check("abort_push", 32'(push_o), 0);
        check("abort_pop", 32'(pop_o), 0);
        @(posedge clk);
        #1;
        check("abort_hold_pop", 32'(pop_o), 0);
        clr_ops();
        rst_n = 1'b1;
        step();
        check("reboot_fetch", 32'(fetch_o), 1);
        check("reboot_pc", 32'(pc_o), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
